// File: rtl/nibble_crypt_pkg.sv
// nibble_crypt_pkg: width, key rotation and FSM states shared by the nibble encoder/decoder pair
package nibble_crypt_pkg;
  localparam int W = 4;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [W-1:0] rotl1(input logic [W-1:0] k);
    return {k[W-2:0], k[W-1]};
  endfunction
endpackage

// File: rtl/nibble_stream_decoder_if.sv
// nibble_stream_decoder_if: cipher-in and plaintext-out valid/ready streams of the decoder
interface nibble_stream_decoder_if #(parameter int W = nibble_crypt_pkg::W);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_word, out_word;
  modport master(output in_valid, in_word, out_ready, input in_ready, out_valid, out_word);
  modport slave(input in_valid, in_word, out_ready, output in_ready, out_valid, out_word);
endinterface

// File: rtl/nibble_fifo2.sv
// nibble_fifo2: 2-deep FIFO whose head register drives the output directly
module nibble_fifo2 #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [1:0] occ;
  logic [W-1:0] tail;
  logic do_push, do_pop;
  assign full = occ == 2'd2;
  assign empty = occ == 2'd0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (rst) begin
      occ <= '0;
      dout <= '0;
      tail <= '0;
    end else begin
      occ <= occ + 2'(do_push) - 2'(do_pop);
      if (do_pop && full) dout <= tail;
      else if (do_push && (empty || do_pop)) dout <= din;
      if (do_push && !empty && !do_pop) tail <= din;
    end
endmodule

// File: rtl/nibble_stream_decoder.sv
// nibble_stream_decoder: XOR-decrypts cipher nibbles with an optionally rolling key
module nibble_stream_decoder
  import nibble_crypt_pkg::*;
#(
  parameter int W = nibble_crypt_pkg::W,
  parameter bit ROLL = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [W-1:0]     key_in,
  nibble_stream_decoder_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] count
);
  state_t state;
  logic [W-1:0] key_reg;
  logic full, empty, push;
  assign bus.in_ready = state == RUN && !full && !key_load;
  assign push = bus.in_valid && bus.in_ready && !rst;
  assign bus.out_valid = !empty;
  nibble_fifo2 #(.W(W)) u_fifo (
    .clk,
    .rst,
    .push,
    .pop(bus.out_valid && bus.out_ready),
    .din(bus.in_word ^ key_reg),
    .dout(bus.out_word),
    .full,
    .empty
  );
  // key_load wins over accept; in_ready already blocks input in that cycle
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      key_reg <= '0;
      count <= '0;
    end else if (key_load) begin
      state <= RUN;
      busy <= 1'b1;
      key_reg <= key_in;
      count <= '0;
    end else if (push) begin
      count <= count + 1'b1;
      key_reg <= ROLL ? rotl1(key_reg) : key_reg;
    end
endmodule
